// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads and
// buffers returned {pc, inst} pairs in a small FIFO for the core.
module inst_fetch #(
  parameter int unsigned         WORD_LEN = 32,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                inst_valid,
  output logic [WORD_LEN-1:0] inst,
  output logic [WORD_LEN-1:0] inst_pc,
  input  logic                inst_ready,
  input  logic                redirect,
  input  logic [WORD_LEN-1:0] redirect_pc,
  input  logic                halt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [WORD_LEN-1:0] r_fetch_pc;
  logic [WORD_LEN-1:0] r_req_pc;
  logic [WORD_LEN-1:0] r_fifo_pc   [DEPTH];
  logic [WORD_LEN-1:0] r_fifo_inst [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;

  // Requests are only issued with a free slot, so a returning word always fits.
  assign mem_req  = rst_n && (r_state == StIdle) && (r_count < CNT_W'(DEPTH)) &&
                    !halt && !redirect;
  assign mem_addr = r_fetch_pc;
  assign w_issue  = mem_req && mem_ready;
  assign w_push   = (r_state == StWait) && mem_rvalid && !redirect;
  assign w_pop    = inst_valid && inst_ready && !redirect;

  assign inst_valid = (r_count != '0);
  assign inst       = r_fifo_inst[r_rd_ptr];
  assign inst_pc    = r_fifo_pc[r_rd_ptr];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_issue) w_state_next = StWait;
      StWait: begin
        if (mem_rvalid) begin
          w_state_next = StIdle;
        end else if (redirect) begin
          w_state_next = StDrop;
        end
      end
      StDrop: if (mem_rvalid) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + WORD_LEN'(4);
      r_req_pc   <= r_fetch_pc;
    end
  end

  // A redirect flushes the buffer outright; any pop in that cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_fifo_inst[r_wr_ptr] <= mem_rdata;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a boot vector table, then a latency-modelling memory with an
// expected-instruction queue for redirect, halt, backpressure, wrap and random traffic.
module tb_inst_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;

  always #5 clk = ~clk;

  inst_fetch #(
    .WORD_LEN (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic        mready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        iready;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];
  bit          pend;
  bit          pend_stale;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat;
  logic        mem_ready_cfg;
  logic [31:0] exp_fetch;
  vec_t        tbl [8];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic void chk32(input string name, input logic [31:0] got,
                                input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endfunction

  function automatic void chk1(input string name, input logic got, input logic expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, expv);
    end
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    pend        = 1'b0;
    pend_stale  = 1'b0;
    exp_fetch   = 32'h0;
    exp_q.delete();
    acc_q.delete();
    pop_q.delete();
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  // One cycle with the memory model driving the response side.
  task automatic cyc(input logic ir, input logic rd, input logic [31:0] rpc, input logic hl);
    logic rv;
    logic exp_req;
    exp_t e;
    @(negedge clk);
    inst_ready  = ir;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    mem_ready   = mem_ready_cfg;
    rv          = pend && (pend_cnt == 0);
    mem_rvalid  = rv;
    mem_rdata   = rv ? word_of(pend_addr) : $urandom();
    #1;
    exp_req = !pend && (exp_q.size() < DEPTH) && !hl && !rd;
    chk1("mem_req", mem_req, exp_req);
    chk32("mem_addr", mem_addr, exp_fetch);
    chk1("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0 && ir && !rd) begin
      e = exp_q.pop_front();
      chk32("inst_pc", inst_pc, e.pc);
      chk32("inst", inst, e.word);
      pop_q.push_back(inst_pc);
    end
    if (rd) exp_q.delete();
    if (rv) begin
      if (!pend_stale && !rd) exp_q.push_back('{pend_addr, word_of(pend_addr)});
      pend = 1'b0;
    end else if (pend) begin
      if (rd) pend_stale = 1'b1;
      pend_cnt--;
    end
    if (mem_req && mem_ready) begin
      acc_q.push_back(mem_addr);
      pend       = 1'b1;
      pend_stale = 1'b0;
      pend_addr  = exp_fetch;
      pend_cnt   = lat - 1;
    end
    if (rd) begin
      exp_fetch = rpc;
    end else if (exp_req && mem_ready) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    lat           = 1;
    mem_ready_cfg = 1'b1;

    // Boot with 1-cycle memory and a always-ready core.
    tbl[0] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, word_of(32'd0), 1'b1, 1'b0, 32'd4,  1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[3] = '{1'b1, 1'b1, word_of(32'd4), 1'b1, 1'b0, 32'd8,  1'b0, 32'd0};
    tbl[4] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
    tbl[5] = '{1'b1, 1'b1, word_of(32'd8), 1'b1, 1'b0, 32'd12, 1'b0, 32'd0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[7] = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'd12, 1'b0, 32'd0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready  = tbl[i].mready;
      mem_rvalid = tbl[i].rvalid;
      mem_rdata  = tbl[i].rdata;
      inst_ready = tbl[i].iready;
      #1;
      chk1($sformatf("tbl%0d_req", i), mem_req, tbl[i].ereq);
      chk32($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].eaddr);
      chk1($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].evalid);
      if (tbl[i].evalid) begin
        chk32($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].epc);
        chk32($sformatf("tbl%0d_inst", i), inst, word_of(tbl[i].epc));
      end
      @(posedge clk);
    end

    // Backpressure: buffer fills at two entries, then drains in order.
    do_reset();
    lat = 1;
    repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("bp_accepts", 32'(acc_q.size()), 32'd2);
    repeat (8) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk32("bp_pop0", q_at(pop_q, 0), 32'h0);
    chk32("bp_pop1", q_at(pop_q, 1), 32'h4);
    chk32("bp_resume_addr", q_at(acc_q, 2), 32'h8);

    // Redirect while a 3-cycle read is outstanding.
    do_reset();
    lat = 3;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h100, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk32("rw_next_addr", q_at(acc_q, 1), 32'h100);
    chk32("rw_first_pc", q_at(pop_q, 0), 32'h100);

    // Redirect coincident with response and pop, one entry buffered.
    do_reset();
    lat = 1;
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h200, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk32("co_pops", 32'(pop_q.size()), 32'd0);
    chk32("co_next_addr", q_at(acc_q, 2), 32'h200);
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk32("co_first_pc", q_at(pop_q, 0), 32'h200);

    // Halt during an outstanding read.
    do_reset();
    lat = 3;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk32("halt_accepts", 32'(acc_q.size()), 32'd1);
    chk32("halt_delivered", q_at(pop_q, 0), 32'h0);
    repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk32("halt_resume_addr", q_at(acc_q, 1), 32'h4);

    // Address wrap at the top of the space.
    do_reset();
    lat = 1;
    cyc(1'b1, 1'b1, 32'hffff_fffc, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk32("wrap_addr0", q_at(acc_q, 0), 32'hffff_fffc);
    chk32("wrap_addr1", q_at(acc_q, 1), 32'h0);
    chk32("wrap_pc0", q_at(pop_q, 0), 32'hffff_fffc);
    chk32("wrap_pc1", q_at(pop_q, 1), 32'h0);

    // Random mix of latency, stalls, halts and redirects.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lat           = int'($urandom_range(1, 3));
      mem_ready_cfg = 1'($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
          $urandom() & 32'hffff_fffc, 1'($urandom_range(0, 7) == 0));
    end
    mem_ready_cfg = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
